// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: states, opcodes and mux selects.
// MC_CTRL_ADDI_EN enables decoding of addi (opcode 0x08); otherwise it is reported as illegal.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_RD    = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WR    = 4'd5,
        R_EXEC    = 4'd6,
        R_WB      = 4'd7,
        BRANCH    = 4'd8,
        JUMP      = 4'd9,
        ADDI_EXEC = 4'd10,
        ADDI_WB   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    function automatic logic op_supported(input logic [5:0] op);
        logic ok;
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J: ok = 1'b1;
`ifdef MC_CTRL_ADDI_EN
            OP_ADDI: ok = 1'b1;
`else
            OP_ADDI: ok = 1'b0;
`endif
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Combinational decode of controller state into datapath selects and strobes.
// MC_CTRL_ADDI_EN adds the ADDI_EXEC/ADDI_WB output rows.
module multicycle_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  state_t      state,
    input  logic [5:0]  opcode,
    input  logic        mem_ready,
    input  logic        zero,
    input  logic        rst,
    output logic        pc_en,
    output logic        iord,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        reg_write,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [1:0]  pc_source,
    output logic        instr_done,
    output logic        illegal_op
);

    logic pc_write;
    logic pc_write_cond;

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_B;
        alu_op        = ALU_ADD;
        pc_source     = PCSRC_ALU;
        instr_done    = 1'b0;
        illegal_op    = 1'b0;

        case (state)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                pc_write  = mem_ready;
                ir_write  = mem_ready;
            end
            DECODE: begin
                alu_src_b = SRCB_IMM_SH2;
                if (!op_supported(opcode)) begin
                    illegal_op = 1'b1;
                    instr_done = 1'b1;
                end
            end
            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            MEM_WR: begin
                mem_write  = 1'b1;
                iord       = 1'b1;
                instr_done = mem_ready;
            end
            R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
            end
            R_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
            end
            BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
                instr_done    = 1'b1;
            end
            JUMP: begin
                pc_write   = 1'b1;
                pc_source  = PCSRC_JUMP;
                instr_done = 1'b1;
            end
`ifdef MC_CTRL_ADDI_EN
            ADDI_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            ADDI_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
`endif
            default: ;
        endcase

        pc_en = pc_write | (pc_write_cond & zero);

        // Reset must not leak any write or handshake into the datapath.
        if (rst) begin
            pc_en      = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            ir_write   = 1'b0;
            reg_write  = 1'b0;
            instr_done = 1'b0;
            illegal_op = 1'b0;
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM: state register and next-state logic; outputs come from the decoder.
// MC_CTRL_ADDI_EN enables the addi execute/writeback path.
module multicycle_ctrl
    import mips_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_en,
    output logic        iord,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        reg_write,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [1:0]  pc_source,
    output logic        instr_done,
    output logic        illegal_op,
    output logic [3:0]  state
);

    state_t state_q;
    state_t state_d;

    always_ff @(posedge clk) begin
        if (rst) state_q <= FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:    if (mem_ready) state_d = DECODE;
            DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_d = R_EXEC;
                    OP_LW, OP_SW: state_d = MEM_ADDR;
                    OP_BEQ:       state_d = BRANCH;
                    OP_J:         state_d = JUMP;
`ifdef MC_CTRL_ADDI_EN
                    OP_ADDI:      state_d = ADDI_EXEC;
`endif
                    default:      state_d = FETCH;
                endcase
            end
            // IR still holds the instruction, so opcode picks the load/store leg here.
            MEM_ADDR: state_d = (opcode == OP_SW) ? MEM_WR : MEM_RD;
            MEM_RD:   if (mem_ready) state_d = MEM_WB;
            MEM_WB:   state_d = FETCH;
            MEM_WR:   if (mem_ready) state_d = FETCH;
            R_EXEC:   state_d = R_WB;
            R_WB:     state_d = FETCH;
            BRANCH:   state_d = FETCH;
            JUMP:     state_d = FETCH;
`ifdef MC_CTRL_ADDI_EN
            ADDI_EXEC: state_d = ADDI_WB;
            ADDI_WB:   state_d = FETCH;
`endif
            default:  state_d = FETCH;
        endcase
    end

    assign state = state_q;

    multicycle_ctrl_decode u_decode (
        .state      (state_q),
        .opcode     (opcode),
        .mem_ready  (mem_ready),
        .zero       (zero),
        .rst        (rst),
        .pc_en      (pc_en),
        .iord       (iord),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .pc_source  (pc_source),
        .instr_done (instr_done),
        .illegal_op (illegal_op)
    );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: a per-instruction cycle plan built from the
// instruction-level description is compared cycle by cycle against the controller outputs.
module tb_multicycle_ctrl;

    typedef struct packed {
        logic [3:0] st;
        logic       pc_en;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
        logic       illegal_op;
    } obs_t;

    typedef struct packed {
        logic ready;
        logic z;
    } drv_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'h00;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
    logic       alu_src_a, instr_done, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state;

    int vectors = 0;
    int miscompares = 0;

    drv_t drv_q[$];
    obs_t exp_q[$];
    obs_t got_q[$];

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_en(pc_en), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .pc_source(pc_source), .instr_done(instr_done),
        .illegal_op(illegal_op), .state(state)
    );

    function automatic obs_t observe();
        obs_t o;
        o.st = state;           o.pc_en = pc_en;           o.iord = iord;
        o.mem_read = mem_read;  o.mem_write = mem_write;   o.ir_write = ir_write;
        o.reg_dst = reg_dst;    o.mem_to_reg = mem_to_reg; o.reg_write = reg_write;
        o.alu_src_a = alu_src_a; o.alu_src_b = alu_src_b;  o.alu_op = alu_op;
        o.pc_source = pc_source; o.instr_done = instr_done; o.illegal_op = illegal_op;
        return o;
    endfunction

    function automatic logic [6:0] strobes();
        return {pc_en, mem_read, mem_write, ir_write, reg_write, instr_done, illegal_op};
    endfunction

    function automatic bit supported(input logic [5:0] op);
        if (op == 6'h08) begin
`ifdef MC_CTRL_ADDI_EN
            return 1'b1;
`else
            return 1'b0;
`endif
        end
        return (op == 6'h00) || (op == 6'h23) || (op == 6'h2B) || (op == 6'h04) || (op == 6'h02);
    endfunction

    // Instruction latency from the published cycle counts plus memory wait cycles.
    function automatic int latency(input logic [5:0] op, input int fwait, input int mwait);
        if (!supported(op))               return 2 + fwait;
        if (op == 6'h23)                  return 5 + fwait + mwait;
        if (op == 6'h2B)                  return 4 + fwait + mwait;
        if (op == 6'h00 || op == 6'h08)   return 4 + fwait;
        return 3 + fwait;
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push(input obs_t e, input logic rdy, input logic z);
        drv_t d;
        d.ready = rdy;
        d.z = z;
        drv_q.push_back(d);
        exp_q.push_back(e);
    endtask

    // Expected per-cycle behaviour of one instruction, written from its step list.
    task automatic plan_instr(input logic [5:0] op, input logic z, input int fwait, input int mwait);
        obs_t e;
        for (int i = 0; i <= fwait; i++) begin
            e = '0; e.st = 4'd0; e.mem_read = 1'b1; e.alu_src_b = 2'b01;
            e.pc_en = (i == fwait); e.ir_write = (i == fwait);
            push(e, i == fwait, rbit());
        end
        e = '0; e.st = 4'd1; e.alu_src_b = 2'b11;
        if (!supported(op)) begin
            e.instr_done = 1'b1; e.illegal_op = 1'b1;
            push(e, rbit(), rbit());
            return;
        end
        push(e, rbit(), rbit());
        if (op == 6'h00) begin
            e = '0; e.st = 4'd6; e.alu_src_a = 1'b1; e.alu_op = 2'b10; push(e, rbit(), rbit());
            e = '0; e.st = 4'd7; e.reg_write = 1'b1; e.reg_dst = 1'b1; e.instr_done = 1'b1;
            push(e, rbit(), rbit());
        end else if (op == 6'h23 || op == 6'h2B) begin
            e = '0; e.st = 4'd2; e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; push(e, rbit(), rbit());
            for (int i = 0; i <= mwait; i++) begin
                e = '0; e.iord = 1'b1;
                if (op == 6'h23) begin
                    e.st = 4'd3; e.mem_read = 1'b1;
                end else begin
                    e.st = 4'd5; e.mem_write = 1'b1; e.instr_done = (i == mwait);
                end
                push(e, i == mwait, rbit());
            end
            if (op == 6'h23) begin
                e = '0; e.st = 4'd4; e.reg_write = 1'b1; e.mem_to_reg = 1'b1; e.instr_done = 1'b1;
                push(e, rbit(), rbit());
            end
        end else if (op == 6'h04) begin
            e = '0; e.st = 4'd8; e.alu_src_a = 1'b1; e.alu_op = 2'b01; e.pc_source = 2'b01;
            e.pc_en = z; e.instr_done = 1'b1;
            push(e, rbit(), z);
        end else if (op == 6'h02) begin
            e = '0; e.st = 4'd9; e.pc_en = 1'b1; e.pc_source = 2'b10; e.instr_done = 1'b1;
            push(e, rbit(), rbit());
        end else begin
            e = '0; e.st = 4'd10; e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; push(e, rbit(), rbit());
            e = '0; e.st = 4'd11; e.reg_write = 1'b1; e.instr_done = 1'b1; push(e, rbit(), rbit());
        end
    endtask

    // Drives the planned inputs one cycle at a time and records what the controller shows.
    task automatic run_plan(input logic [5:0] op);
        drv_t d;
        got_q.delete();
        while (drv_q.size() > 0) begin
            d = drv_q.pop_front();
            @(posedge clk); #1;
            opcode = op; mem_ready = d.ready; zero = d.z;
            @(negedge clk);
            got_q.push_back(observe());
        end
    endtask

    function automatic int first_done();
        foreach (got_q[i]) if (got_q[i].instr_done === 1'b1) return i + 1;
        return -1;
    endfunction

    task automatic test_reset();
        rst = 1'b1; opcode = 6'h02; zero = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1; mem_ready = rbit();
            @(negedge clk);
            vectors++;
            if (state !== 4'd0 || strobes() !== 7'd0) begin
                miscompares++;
                $display("[TB] FAIL reset_hold cycle %0d: state=%0d strobes=%b, want state=0 strobes=0000000", i, state, strobes());
            end
        end
        @(posedge clk); #1; rst = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        vectors++;
        if (state !== 4'd0 || mem_read !== 1'b1 || iord !== 1'b0 || pc_en !== 1'b0 || ir_write !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_release: state=%0d mem_read=%b iord=%b pc_en=%b ir_write=%b, want 0 1 0 0 0",
                     state, mem_read, iord, pc_en, ir_write);
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1; opcode = 6'h00; mem_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1; rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (state !== 4'd6 || strobes() !== 7'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_exec: state=%0d strobes=%b, want state=6 strobes=0000000", state, strobes());
        end
        @(posedge clk); #1; rst = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        vectors++;
        if (state !== 4'd0 || reg_write !== 1'b0 || mem_read !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_abandon: state=%0d reg_write=%b mem_read=%b, want 0 0 1", state, reg_write, mem_read);
        end
    endtask

    // One instruction: per-cycle comparison plus the latency check.
    task automatic test_instr(input string name, input logic [5:0] op, input logic z, input int fwait, input int mwait);
        int done_at;
        exp_q.delete();
        plan_instr(op, z, fwait, mwait);
        run_plan(op);
        foreach (exp_q[i]) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("[TB] FAIL %s op=%h cycle %0d: got %h want %h", name, op, i + 1, got_q[i], exp_q[i]);
            end
        end
        done_at = first_done();
        vectors++;
        if (done_at != latency(op, fwait, mwait)) begin
            miscompares++;
            $display("[TB] FAIL %s_latency op=%h: done in cycle %0d, want %0d", name, op, done_at, latency(op, fwait, mwait));
        end
    endtask

    task automatic test_fetch_stall();
        int n_pc;
        int n_ir;
        test_instr("fetch_stall", 6'h00, 1'b0, 4, 0);
        n_pc = 0; n_ir = 0;
        foreach (got_q[i]) begin
            n_pc += int'(got_q[i].pc_en);
            n_ir += int'(got_q[i].ir_write);
        end
        vectors++;
        if (n_pc != 1 || n_ir != 1) begin
            miscompares++;
            $display("[TB] FAIL fetch_stall_strobes: pc_en cycles=%0d ir_write cycles=%0d, want 1 and 1", n_pc, n_ir);
        end
    endtask

    task automatic test_random();
        logic [5:0] ops [8];
        logic [5:0] op;
        ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08, 6'h3F, 6'h00};
        for (int n = 0; n < 40; n++) begin
            op = ops[$urandom_range(0, 7)];
            if (n % 8 == 7) op = 6'($urandom_range(0, 63));
            test_instr("random", op, rbit(), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        test_reset();
        test_instr("rtype", 6'h00, 1'b0, 0, 0);
        test_instr("lw_wait2", 6'h23, 1'b0, 0, 2);
        test_instr("sw", 6'h2B, 1'b1, 0, 0);
        test_instr("sw_wait1", 6'h2B, 1'b0, 1, 1);
        test_instr("beq_taken", 6'h04, 1'b1, 0, 0);
        test_instr("beq_not_taken", 6'h04, 1'b0, 0, 0);
        test_instr("jump", 6'h02, 1'b0, 0, 0);
        test_fetch_stall();
        test_instr("illegal", 6'h3F, 1'b0, 0, 0);
        test_instr("addi", 6'h08, 1'b0, 0, 0);
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
